// File: rtl/decoder_pkg.sv
// Shared decoder definitions: stage-sequencer FSM encoding, stage indices and
// default scheduling limits.
package decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_ERROR   = 3'd4
  } seq_state_e;

  localparam int DEF_NUM_STAGES     = 32'sd6;
  localparam int DEF_TIMEOUT_CYCLES = 32'sd1048575;
  localparam int DEF_TIMEOUT_W      = 32'sd20;

  localparam int STG_HUFFMAN   = 32'sd0;
  localparam int STG_REQUANT   = 32'sd1;
  localparam int STG_REORDER   = 32'sd2;
  localparam int STG_STEREO    = 32'sd3;
  localparam int STG_ANTIALIAS = 32'sd4;
  localparam int STG_IMDCT     = 32'sd5;

  function automatic logic [31:0] stage_bit(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Loadable saturating cycle counter guarding one stage's ready-to-done time.
module stage_watchdog
  import decoder_pkg::*;
#(
  parameter int W     = DEF_TIMEOUT_W,
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expired
);

  // Expires when the next increment would reach LIMIT, so the caller can act on that same edge.
  localparam logic [W-1:0] EXPIRE_AT = W'(LIMIT - 32'sd1);
  localparam logic [W-1:0] COUNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] COUNT_ONE = W'(32'd1);

  logic [W-1:0] count_r;

  // Counter update: clear, then load, then saturating increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != COUNT_MAX)) begin
      count_r <= count_r + COUNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r >= EXPIRE_AT);

endmodule

// File: rtl/stage_sequencer.sv
// Per-frame scheduler: pulses each granule stage in turn, waits for its done,
// repeats per granule, and flags stages that never answer.
module stage_sequencer
  import decoder_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W      = DEF_TIMEOUT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          header_mpeg1,
  output logic [NUM_STAGES-1:0]         stage_ready,
  input  logic [NUM_STAGES-1:0]         stage_done,
  output logic                          granule_index,
  output logic [$clog2(NUM_STAGES)-1:0] active_stage,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          timeout_error
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam logic [SW-1:0]        LAST_STAGE = SW'(NUM_STAGES - 32'sd1);
  localparam logic [SW-1:0]        STAGE_ONE  = SW'(32'd1);
  // The ISSUE cycle already counts as the first elapsed cycle of the stage.
  localparam logic [TIMEOUT_W-1:0] WD_LOAD    = TIMEOUT_W'(32'd1);

  seq_state_e    state_r;
  logic          last_granule_r;
  logic          wd_clear_s;
  logic          wd_load_s;
  logic          wd_enable_s;
  logic          wd_expired_s;
  logic          active_done_s;
  logic          frame_last_s;
  logic [SW-1:0] next_stage_s;

  assign wd_load_s     = (state_r == ST_ISSUE);
  assign wd_enable_s   = (state_r == ST_WAIT);
  assign wd_clear_s    = !(wd_load_s || wd_enable_s);
  assign active_done_s = stage_done[active_stage];
  assign frame_last_s  = (active_stage == LAST_STAGE) && (granule_index == last_granule_r);
  assign next_stage_s  = active_stage + STAGE_ONE;

  stage_watchdog #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear      (wd_clear_s),
    .load       (wd_load_s),
    .load_value (WD_LOAD),
    .enable     (wd_enable_s),
    .expired    (wd_expired_s)
  );

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      last_granule_r <= 1'b0;
      stage_ready    <= {NUM_STAGES{1'b0}};
      granule_index  <= 1'b0;
      active_stage   <= {SW{1'b0}};
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      timeout_error  <= 1'b0;
    end else begin
      stage_ready <= {NUM_STAGES{1'b0}};
      frame_done  <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ERROR: begin
          if (frame_start) begin
            last_granule_r <= header_mpeg1;
            granule_index  <= 1'b0;
            active_stage   <= {SW{1'b0}};
            timeout_error  <= 1'b0;
            busy           <= 1'b1;
            stage_ready    <= NUM_STAGES'(stage_bit(32'd0));
            state_r        <= ST_ISSUE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done in the expiry cycle still counts as a completion.
          if (active_done_s) begin
            state_r <= ST_ADVANCE;
            if (frame_last_s) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              busy <= 1'b1;
            end
          end else if (wd_expired_s) begin
            timeout_error <= 1'b1;
            busy          <= 1'b0;
            state_r       <= ST_ERROR;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_ADVANCE: begin
          if (active_stage != LAST_STAGE) begin
            active_stage <= next_stage_s;
            stage_ready  <= NUM_STAGES'(stage_bit(32'(next_stage_s)));
            state_r      <= ST_ISSUE;
          end else if (granule_index != last_granule_r) begin
            granule_index <= 1'b1;
            active_stage  <= {SW{1'b0}};
            stage_ready   <= NUM_STAGES'(stage_bit(32'd0));
            state_r       <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench: randomized frames compared against a cycle-schedule
// model of the sequencer (ready/done/timeout timing derived arithmetically).
module tb_stage_sequencer;

  localparam int NS = 3;
  localparam int TO = 16;
  localparam int TW = 5;
  localparam int AW = $clog2(NS);

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          header_mpeg1;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_done;
  logic          granule_index;
  logic [AW-1:0] active_stage;
  logic          busy;
  logic          frame_done;
  logic          timeout_error;

  int n_checks = 0;
  int n_errors = 0;
  bit prev_err = 1'b0;

  stage_sequencer #(
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .header_mpeg1  (header_mpeg1),
    .stage_ready   (stage_ready),
    .stage_done    (stage_done),
    .granule_index (granule_index),
    .active_stage  (active_stage),
    .busy          (busy),
    .frame_done    (frame_done),
    .timeout_error (timeout_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NS-1:0] onehot(input int i);
    return NS'(32'd1 << i);
  endfunction

  // One frame: build the expected event schedule, then drive and compare per cycle.
  // Cycle 0 is the frame_start cycle; outputs are sampled 1 time unit after each edge.
  task automatic run_frame(input bit mpeg1, input int fixed_lat, input int hang_k,
                           input int hang_lat, input bit noise);
    int n_ev, err_c, fd_c, last_k, stop_c, end_c, cur;
    int lat [2*NS];
    int rdy [2*NS];
    int dn  [2*NS];
    logic [NS-1:0] exp_rdy;
    logic [NS-1:0] drv_done;
    n_ev   = mpeg1 ? 2*NS : NS;
    err_c  = -1;
    fd_c   = -1;
    last_k = 0;
    cur    = 0;
    for (int k = 0; k < 2*NS; k++) begin
      lat[k] = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(9, 1));
      if (k == hang_k) begin
        if (hang_lat > 0) lat[k] = hang_lat;
        else begin
          case ($urandom_range(3, 0))
            0:       lat[k] = TO - 1;
            1:       lat[k] = TO;
            2:       lat[k] = TO + 1;
            default: lat[k] = 300;
          endcase
        end
      end
      rdy[k] = 0;
      dn[k]  = 0;
    end
    rdy[0] = 1;
    for (int k = 0; k < n_ev; k++) begin
      last_k = k;
      dn[k]  = rdy[k] + lat[k];
      if (lat[k] >= TO) begin
        err_c = rdy[k] + TO;
        break;
      end
      if (k + 1 < n_ev) rdy[k+1] = dn[k] + 2;
      else fd_c = dn[k] + 1;
    end
    stop_c = (err_c >= 0) ? err_c : fd_c;
    end_c  = stop_c + 3;

    for (int c = 0; c <= end_c; c++) begin
      exp_rdy = '0;
      for (int k = 0; k <= last_k; k++) begin
        if (c == rdy[k]) begin
          exp_rdy = onehot(k % NS);
          cur     = k;
        end
      end
      check_val("stage_ready", 32'(stage_ready), 32'(exp_rdy));
      if (exp_rdy != '0) begin
        check_val("active_stage", 32'(active_stage), 32'(cur % NS));
        check_val("granule_index", 32'(granule_index), 32'(cur / NS));
      end
      check_val("busy", 32'(busy), 32'((c >= 1) && (c < stop_c)));
      check_val("frame_done", 32'(frame_done), 32'(c == fd_c));
      check_val("timeout_error", 32'(timeout_error),
                32'((c == 0) ? prev_err : ((err_c >= 0) && (c >= err_c))));
      if (c == end_c) begin
        check_val("hold_active_stage", 32'(active_stage), 32'(last_k % NS));
        check_val("hold_granule_index", 32'(granule_index), 32'(last_k / NS));
      end

      frame_start  = (c == 0) || ((c >= 1) && (c < stop_c) && ($urandom_range(5, 0) == 0));
      header_mpeg1 = (c == 0) ? mpeg1 : ($urandom_range(1, 0) != 0);
      drv_done = '0;
      for (int k = 0; k <= last_k; k++) begin
        if (c == dn[k]) drv_done = onehot(k % NS);
        else if (noise && (c >= rdy[k]) && (c < dn[k])) begin
          drv_done = NS'($urandom);
          if (c != rdy[k]) drv_done = drv_done & ~onehot(k % NS);
        end
      end
      stage_done = drv_done;
      tick();
    end
    frame_start = 1'b0;
    stage_done  = '0;
    prev_err    = (err_c >= 0);
  endtask

  // Reset pulse during the WAIT of stage 1 aborts the frame outright.
  task automatic reset_mid_frame();
    for (int c = 0; c < 20; c++) begin
      if (c == 6) check_val("rst_pre_ready1", 32'(stage_ready), 32'(onehot(1)));
      if (c == 9) begin
        check_val("rst_ready", 32'(stage_ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_timeout", 32'(timeout_error), 32'd0);
        check_val("rst_active_stage", 32'(active_stage), 32'd0);
        check_val("rst_granule", 32'(granule_index), 32'd0);
      end
      if (c >= 10) begin
        check_val("post_rst_ready", 32'(stage_ready), 32'd0);
        check_val("post_rst_busy", 32'(busy), 32'd0);
      end
      frame_start  = (c == 0);
      header_mpeg1 = 1'b1;
      stage_done   = (c == 4) ? onehot(0) : ((c == 12) ? onehot(1) : '0);
      rst          = (c == 8) ? 1'b0 : 1'b1;
      tick();
    end
    stage_done = '0;
    prev_err   = 1'b0;
  endtask

  initial begin
    bit mp;
    int hk;
    rst          = 1'b0;
    frame_start  = 1'b0;
    header_mpeg1 = 1'b0;
    stage_done   = '0;
    repeat (3) tick();
    check_val("reset_ready", 32'(stage_ready), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_frame_done", 32'(frame_done), 32'd0);
    check_val("reset_timeout", 32'(timeout_error), 32'd0);
    check_val("reset_active_stage", 32'(active_stage), 32'd0);
    check_val("reset_granule", 32'(granule_index), 32'd0);
    rst = 1'b1;
    tick();

    run_frame(1'b1, 5, -1, 0, 1'b0);
    run_frame(1'b0, 5, -1, 0, 1'b0);
    run_frame(1'b1, 0, -1, 0, 1'b1);
    run_frame(1'b1, 4, 1, 1000, 1'b0);
    run_frame(1'b0, 3, -1, 0, 1'b1);
    run_frame(1'b0, 2, 2, TO - 1, 1'b1);
    reset_mid_frame();
    run_frame(1'b1, 0, -1, 0, 1'b0);

    for (int f = 0; f < 30; f++) begin
      mp = ($urandom_range(1, 0) != 0);
      hk = ($urandom_range(3, 0) == 0) ? int'($urandom_range(mp ? 5 : 2, 0)) : -1;
      run_frame(mp, 0, hk, 0, ($urandom_range(1, 0) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Per-frame scheduler for the decoder's granule-processing stage chain (huffman, requantize, reorder, stereo, antialias, imdct, ...).
- Issues one-cycle `stage_ready` pulses to each stage in order and waits for that stage's `stage_done` pulse before starting the next.
- Repeats the chain for every granule of the frame, exports the current granule index for granule-memory bank selection, and flags hung stages via a watchdog.

Parameters:
- NUM_STAGES, 6, number of chained stages; bit i of the ready/done vectors belongs to stage i, executed in ascending order.
- TIMEOUT_CYCLES, 1048575, maximum cycles a stage may take from its ready pulse to its done pulse before the watchdog fires.
- TIMEOUT_W, 20, width of the watchdog counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next posedge).
- frame_start  in  1  one-cycle pulse: sideinfo/header for a new frame valid, begin processing.
- header_mpeg1  in  1  sampled on accepted frame_start: 1 = two granules per frame, 0 = one granule (MPEG-2/2.5).
- stage_ready  out  NUM_STAGES  one-hot, one-cycle start pulse to stage i.
- stage_done  in  NUM_STAGES  one-cycle completion pulse from stage i.
- granule_index  out  1  granule currently being processed.
- active_stage  out  $clog2(NUM_STAGES)  index of the stage currently running.
- busy  out  1  high from the accepted frame_start until frame_done or error.
- frame_done  out  1  one-cycle pulse when the last stage of the last granule completes.
- timeout_error  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst==0): FSM to IDLE; all outputs 0; watchdog counter 0; latched granule count 0. Reset mid-frame aborts immediately; no further stage_ready pulses are issued.
- States: IDLE, ISSUE, WAIT, ADVANCE, ERROR.
- IDLE:
  - frame_start=1 latches last_granule = header_mpeg1, clears granule_index, active_stage and timeout_error, and moves to ISSUE.
  - busy is 1 from the following cycle.
- ISSUE (exactly one cycle):
  - stage_ready = 1 << active_stage.
  - Watchdog cleared.
  - Go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - stage_done[active_stage]=1 goes to ADVANCE.
  - Done bits of non-active stages are ignored.
  - Done arriving in the ISSUE cycle itself is ignored, because stages register their ready input.
  - Watchdog reaching TIMEOUT_CYCLES with no done goes to ERROR.
  - A done and a timeout in the same cycle count as done.
- ADVANCE (exactly one cycle):
  - If active_stage < NUM_STAGES-1: active_stage+1, go to ISSUE.
  - Else if granule_index < last_granule: granule_index+1, active_stage=0, go to ISSUE.
  - Else: pulse frame_done, return to IDLE with busy=0 in the same cycle.
- Latencies:
  - frame_start at cycle t gives stage_ready[0] at t+1.
  - stage_done at cycle t gives the next stage_ready at t+2.
  - Last done at cycle t gives frame_done at t+1.
- ERROR:
  - timeout_error=1, busy=0, no pulses issued.
  - Leaves only on the next frame_start, which clears the flag and behaves as an IDLE start, or on reset.
- frame_start while busy is ignored (not queued).
- active_stage and granule_index hold their values in IDLE/ERROR after completion, for debug.
- Watchdog saturates and never wraps.

Decomposition:
- Shared package (decoder_pkg): FSM state encoding, default NUM_STAGES, stage index constants (STG_HUFFMAN, STG_REQUANT, STG_REORDER, ...), and the default TIMEOUT_CYCLES.
- One natural sub-module: stage_watchdog, a loadable saturating counter with clear/enable/expired ports. Everything else stays flat in the FSM.

Test Plan:
- NUM_STAGES=3, header_mpeg1=1, each stage done 5 cycles after its ready -> ready pulses in order 0,1,2,0,1,2 with granule_index 0,0,0,1,1,1; frame_done exactly 1 cycle after the 6th done; busy falls with frame_done.
- header_mpeg1=0 -> only 3 ready pulses, granule_index stays 0, one frame_done.
- Inject stage_done[2] while stage 0 is active, plus a done in the ISSUE cycle -> both ignored; sequencing waits for the genuine stage_done[0].
- TIMEOUT_CYCLES=16, stage 1 never answers -> timeout_error=1 exactly 16 cycles after stage_ready[1], busy=0, no further pulses. A following frame_start clears the error and produces stage_ready[0] on the next cycle.
- Second frame_start while busy, in IDLE/ISSUE/WAIT states -> no effect; exactly one frame_done for the first frame.
- rst=0 held one cycle during WAIT of stage 1 -> all outputs 0 on the next cycle, no stage_ready until a new frame_start.
